exec_stage: RTL

- Pipelined execute stage of the 64-bit Y86-64 datapath; sits directly upstream of the 64-bit AND, XOR and ADD/SUB sub-units.
- Accepts decoded operands, drives the sub-units and selects valE.
- Holds the condition-code (CC) register and evaluates cmovXX/jXX conditions.
- Registers its result into the memory stage through a valid/ready handshake.

---
 rtl/exec_stage.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_stage.sv
// exec_stage: Y86-64 execute stage with CC register and registered result.
// Optional iterative multiply for OPq ifun 4 is enabled by ALU_MUL_EN.
module exec_stage #(
   parameter int W          = 64,
   parameter int MUL_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_icode,
   input  logic [3:0]   in_ifun,
   input  logic [W-1:0] in_valA,
   input  logic [W-1:0] in_valB,
   input  logic [W-1:0] in_valC,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   out_icode,
   output logic [W-1:0] out_valE,
   output logic         out_cnd,
   output logic         out_err,
   output logic         cc_zf,
   output logic         cc_sf,
   output logic         cc_of
);

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t         state_q;
   state_t         state_nx;
   logic [CW-1:0]  cnt_q;

   logic           accept;
   logic           mul_go;
   logic           mul_done;

   logic [W-1:0]   sum;
   logic [W-1:0]   dif;
   logic [W-1:0]   mul_res;

   logic           lt;
   logic           cnd_raw;

   logic           dec_err;
   logic           dec_cnd;
   logic           dec_ccw;
   logic           dec_mul;
   logic           dec_of;
   logic [W-1:0]   dec_vale;

   assign sum = in_valB + in_valA;
   assign dif = in_valB - in_valA;

   // Branch/cmov condition from the CC value held before this edge
   always_comb begin
      lt      = cc_sf ^ cc_of;
      cnd_raw = 1'b0;
      unique case (in_ifun)
         4'h0:    cnd_raw = 1'b1;
         4'h1:    cnd_raw = lt | cc_zf;
         4'h2:    cnd_raw = lt;
         4'h3:    cnd_raw = cc_zf;
         4'h4:    cnd_raw = !cc_zf;
         4'h5:    cnd_raw = !lt;
         4'h6:    cnd_raw = !lt && !cc_zf;
         default: cnd_raw = 1'b0;
      endcase
   end

   // Decode icode/ifun into valE, condition, CC write and error
   always_comb begin
      dec_err  = 1'b0;
      dec_cnd  = 1'b0;
      dec_ccw  = 1'b0;
      dec_mul  = 1'b0;
      dec_of   = 1'b0;
      dec_vale = '0;
      unique case (1'b1)
         (in_icode == 4'h2): begin
            dec_err  = (in_ifun > 4'h6);
            dec_cnd  = cnd_raw;
            dec_vale = in_valA;
         end
         (in_icode == 4'h7): begin
            dec_err = (in_ifun > 4'h6);
            dec_cnd = cnd_raw;
         end
         (in_icode == 4'h3): begin
            dec_vale = in_valC;
         end
         (in_icode == 4'h4) ||
         (in_icode == 4'h5): begin
            dec_vale = in_valB + in_valC;
         end
         (in_icode == 4'h6): begin
            dec_ccw = 1'b1;
            unique case (in_ifun)
               4'h0: begin
                  dec_vale = sum;
                  dec_of   = (in_valA[W-1] == in_valB[W-1])
                          && (sum[W-1] != in_valB[W-1]);
               end
               4'h1: begin
                  dec_vale = dif;
                  dec_of   = (in_valA[W-1] != in_valB[W-1])
                          && (dif[W-1] != in_valB[W-1]);
               end
               4'h2: dec_vale = in_valB & in_valA;
               4'h3: dec_vale = in_valB ^ in_valA;
`ifdef ALU_MUL_EN
               4'h4: dec_mul = 1'b1;
`endif
               default: dec_err = 1'b1;
            endcase
         end
         (in_icode == 4'h8) ||
         (in_icode == 4'hA): begin
            dec_vale = in_valB - W'(8);
         end
         (in_icode == 4'h9) ||
         (in_icode == 4'hB): begin
            dec_vale = in_valB + W'(8);
         end
         (in_icode > 4'hB): begin
            dec_err = 1'b1;
         end
         default: ;
      endcase
      if (dec_err) begin
         dec_vale = '0;
         dec_cnd  = 1'b0;
         dec_ccw  = 1'b0;
         dec_of   = 1'b0;
      end
   end

   // Handshake and FSM-derived controls
   always_comb begin
      in_ready = (state_q == IDLE) && !flush
              && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
      mul_go   = accept && dec_mul;
      mul_done = (state_q == BUSY) && !flush
              && (cnt_q == '0);
   end

   // Next state: BUSY while the multiply iterates
   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         IDLE: if (mul_go) state_nx = BUSY;
         BUSY: if (flush || cnt_q == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nx;
   end

   // Multiply iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (mul_go)
         cnt_q <= CW'(MUL_CYCLES - 1);
      else if (state_q == BUSY && cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

`ifdef ALU_MUL_EN
   localparam int CH = W / MUL_CYCLES;

   logic [W-1:0] mcand_q;
   logic [W-1:0] mplier_q;
   logic [W-1:0] acc_q;
   logic [W-1:0] part;

   assign part    = mcand_q
                  * {{(W-CH){1'b0}}, mplier_q[CH-1:0]};
   assign mul_res = acc_q + part;

   // Shift-add multiply, CH multiplier bits per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (mul_go) begin
         mcand_q  <= in_valA;
         mplier_q <= in_valB;
         acc_q    <= '0;
      end else if (state_q == BUSY) begin
         mcand_q  <= mcand_q << CH;
         mplier_q <= mplier_q >> CH;
         acc_q    <= mul_res;
      end
   end
`else
   assign mul_res = '0;
`endif

   // Result register toward the memory stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_icode <= '0;
         out_valE  <= '0;
         out_cnd   <= 1'b0;
         out_err   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept && !mul_go) begin
         out_valid <= 1'b1;
         out_icode <= in_icode;
         out_valE  <= dec_vale;
         out_cnd   <= dec_cnd;
         out_err   <= dec_err;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         out_icode <= 4'h6;
         out_valE  <= mul_res;
         out_cnd   <= 1'b0;
         out_err   <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Condition codes, written only by completed OPq
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_zf <= 1'b1;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (accept && dec_ccw && !mul_go) begin
         cc_zf <= (dec_vale == '0);
         cc_sf <= dec_vale[W-1];
         cc_of <= dec_of;
      end else if (mul_done) begin
         cc_zf <= (mul_res == '0);
         cc_sf <= mul_res[W-1];
         cc_of <= 1'b0;
      end
   end

endmodule
